l1_mem_responder: RTL and testbench
===================================

L1_MEM_RESPONDER -- requirements
Module: l1_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, backing-store depth in DATA_WIDTH words, power of two.
REQ-002 SHALL have parameter READ_LATENCY, default 4, cycles from read accept to first read beat, range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1: line-request handshake.
REQ-006 SHALL have ports req_write input 1 and req_addr input ADDR_WIDTH: 1 = line writeback, 0 = line fill; byte address.
REQ-007 SHALL have ports wdata_valid input 1, wdata input DATA_WIDTH and wdata_ready output 1: writeback beat stream.
REQ-008 SHALL have ports rdata_valid output 1, rdata output DATA_WIDTH, rdata_last output 1 and rdata_ready input 1: fill beat stream.
REQ-009 SHALL have port wr_done  output  1  one-cycle pulse on writeback completion.

Function
REQ-010 SHALL serve one L1 line per request, L1_BEATS = L1_LINE_SIZE/(DATA_WIDTH/8) = 8 beats, ascending word order.
REQ-011 SHALL clear the low L1_OFFSET bits of req_addr at accept; the line base word = (req_addr >> 2) with the low 3 bits cleared.
REQ-012 SHALL form the word index as (base + beat) mod MEM_WORDS; upper address bits alias.
REQ-013 SHALL implement states IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_RESP.
REQ-014 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready; req_valid in other states is ignored and not queued.
REQ-015 SHALL, on a read accept, go to RD_WAIT, count READ_LATENCY-1 cycles, then enter RD_BURST, so the first rdata_valid occurs READ_LATENCY cycles after the accept edge.
REQ-016 SHALL, in RD_BURST, hold rdata_valid=1 with rdata = mem[index of current beat]; the beat advances only on rdata_valid && rdata_ready; rdata and rdata_last stay stable while rdata_ready=0.
REQ-017 SHALL assert rdata_last with beat 7 only; its handshake returns to IDLE, with req_ready=1 on the next cycle.
REQ-018 SHALL, on a write accept, go to WR_BURST with wdata_ready=1; each wdata_valid && wdata_ready writes wdata to the current index and advances the beat; gaps in wdata_valid are allowed.
REQ-019 SHALL, after the beat-7 write, enter WR_RESP for exactly one cycle with wr_done=1, then return to IDLE.
REQ-020 SHALL drive rdata to 0 whenever rdata_valid=0.
REQ-021 SHALL make a fill issued in the cycle after wr_done return the newly written data (no stale read).

Reset
REQ-022 SHALL, on rst assertion, immediately force state=IDLE, beat and latency counters=0, req_ready=0 while rst=1, and rdata_valid=rdata_last=wdata_ready=wr_done=0, rdata=0.
REQ-023 SHALL abort any in-flight burst on reset; beats already written remain in the array, which is not reset.
REQ-024 SHALL assert req_ready in the first cycle after rst deasserts.

Structure
REQ-025 SHALL add L1_BEATS, L1_BEAT_BITS = $clog2(L1_BEATS) and enum typedef mem_state_t (the five states) to cache_pkg, and use its ADDR_WIDTH, DATA_WIDTH, L1_LINE_SIZE and L1_OFFSET.
REQ-026 SHALL place the storage in sub-module l1_mem_array (1 write port, 1 asynchronous read port, MEM_WORDS x DATA_WIDTH); the FSM and counters stay in l1_mem_responder.

Verification
REQ-027 SHALL cover: write at 0x0000_0040 with beats 0x1000_0000+i, i=0..7 -> wr_done pulses exactly 1 cycle after beat 7; then read at 0x0000_0040 -> first rdata_valid 4 cycles after accept, data 0x1000_0000..0x1000_0007, rdata_last on the 8th beat only.
REQ-028 SHALL cover: read at unaligned 0x0000_005C -> same 8 words as at 0x0000_0040; read at 0x0000_4040 (MEM_WORDS=4096) -> aliased, same data.
REQ-029 SHALL cover: rdata_ready held low 2 cycles at beat 3 -> rdata=0x1000_0003 held stable, no beat skipped or repeated.
REQ-030 SHALL cover: wdata_valid gaps of 1-3 cycles during a writeback -> all 8 words stored correctly; a req_valid pulse mid-burst is ignored.
REQ-031 SHALL cover: rst asserted at read beat 4 -> all outputs 0 in the same cycle; after release, req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-hierarchy parameters and the L1 backing-memory responder state type.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned L1_LINE_SIZE = 32;
    localparam int unsigned L1_OFFSET    = $clog2(L1_LINE_SIZE);

    localparam int unsigned L1_BEATS     = L1_LINE_SIZE / (DATA_WIDTH / 8);
    localparam int unsigned L1_BEAT_BITS = $clog2(L1_BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_RESP
    } mem_state_t;

endpackage

// File: rtl/l1_mem_array.sv
// Word-wide backing store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module l1_mem_array
    import cache_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/l1_mem_responder.sv
// Memory-side responder for L1 line fills and writebacks: one 8-beat line per request,
// with a configurable read latency before the first fill beat.
module l1_mem_responder
    import cache_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    input  logic                  rdata_ready,
    output logic                  wr_done
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned LAT_W = 4;
    // RD_WAIT lasts READ_LATENCY-1 cycles; latency 1 skips it entirely.
    localparam logic [LAT_W-1:0] LAT_LAST =
        LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [L1_BEAT_BITS-1:0] BEAT_LAST = L1_BEAT_BITS'(L1_BEATS - 1);

    mem_state_t              r_state, w_state_nxt;
    logic [L1_BEAT_BITS-1:0] r_beat, w_beat_nxt;
    logic [LAT_W-1:0]        r_lat, w_lat_nxt;
    logic [IDX_W-1:0]        r_base, w_base_nxt;

    logic [IDX_W-1:0]        w_req_base;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_WIDTH-1:0]   w_arr_rdata;
    logic                    w_rd_en;
    logic                    w_we;
    logic                    w_unused_addr;

    // Line base in words: offset bits dropped, upper bits alias modulo MEM_WORDS.
    assign w_req_base    = {req_addr[IDX_W+1:L1_OFFSET], {(L1_OFFSET - 2){1'b0}}};
    assign w_unused_addr = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[L1_OFFSET-1:0]};
    assign w_idx         = r_base + IDX_W'(r_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_lat   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_lat   <= w_lat_nxt;
            r_base  <= w_base_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_lat_nxt   = r_lat;
        w_base_nxt  = r_base;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_base_nxt = w_req_base;
                    w_beat_nxt = '0;
                    w_lat_nxt  = '0;
                    if (req_write) begin
                        w_state_nxt = WR_BURST;
                    end else if (READ_LATENCY == 1) begin
                        w_state_nxt = RD_BURST;
                    end else begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_state_nxt = RD_BURST;
                end else begin
                    w_lat_nxt = r_lat + 1'b1;
                end
            end
            RD_BURST: begin
                if (rdata_ready) begin
                    if (r_beat == BEAT_LAST) begin
                        w_state_nxt = IDLE;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (wdata_valid) begin
                    if (r_beat == BEAT_LAST) begin
                        w_state_nxt = WR_RESP;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            WR_RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // rst gates req_ready combinationally so it is low for the whole reset pulse.
    assign req_ready   = (r_state == IDLE) && !rst;
    assign w_rd_en     = (r_state == RD_BURST);
    assign rdata_valid = w_rd_en;
    assign rdata       = w_rd_en ? w_arr_rdata : '0;
    assign rdata_last  = w_rd_en && (r_beat == BEAT_LAST);
    assign wdata_ready = (r_state == WR_BURST);
    assign wr_done     = (r_state == WR_RESP);
    assign w_we        = wdata_ready && wdata_valid;

    l1_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (wdata),
        .i_raddr (w_idx),
        .o_rdata (w_arr_rdata)
    );

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench for l1_mem_responder: writebacks, fills, aliasing, stalls and reset abort.
module tb_l1_mem_responder;
    import cache_pkg::*;

    localparam int unsigned LAT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  wdata_valid;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wdata_ready;
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_last;
    logic                  rdata_ready;
    logic                  wr_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l1_mem_responder #(
        .MEM_WORDS    (4096),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .wdata_valid (wdata_valid),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .rdata_ready (rdata_ready),
        .wr_done     (wr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'd0);
        check({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
        check({tag, "_rdata"},       rdata,            32'd0);
        check({tag, "_rdata_last"},  32'(rdata_last),  32'd0);
        check({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
        check({tag, "_wr_done"},     32'(wr_done),     32'd0);
    endtask

    // Writes base+i to beat i; gaps of 1..3 idle cycles when gap_en, plus a stray req_valid.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] base,
                            input bit gap_en, input bit poke);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        check("wr_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_wdata_ready", 32'(wdata_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            int gaps;
            gaps = gap_en ? (i % 3) + 1 : 0;
            for (int g = 0; g < gaps; g++) begin
                wdata_valid = 1'b0;
                if (poke && i == 4 && g == 0) begin
                    req_valid = 1'b1;
                    req_write = 1'b0;
                    req_addr  = 32'h0000_0040;
                    check("wr_busy_req_ready", 32'(req_ready), 32'd0);
                end else begin
                    req_valid = 1'b0;
                end
                @(negedge clk);
            end
            req_valid   = 1'b0;
            wdata_valid = 1'b1;
            wdata       = base + i;
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        check("wr_done_pulse", 32'(wr_done), 32'd1);
        check("wr_resp_wdata_ready", 32'(wdata_ready), 32'd0);
    endtask

    // Reads a line expecting base+i; optional 2-cycle stall at stall_beat,
    // optional reset pulse at abort_beat (8 = none).
    task automatic do_read(input logic [31:0] addr, input logic [31:0] base,
                           input int stall_beat, input int abort_beat);
        int lat;
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = addr;
        rdata_ready = 1'b1;
        check("rd_req_ready", 32'(req_ready), 32'd1);
        check("wr_done_width", 32'(wr_done), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        check("rd_wait_rdata", rdata, 32'd0);
        while (!rdata_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 8; i++) begin
            if (i == abort_beat) begin
                rst = 1'b1;
                #1;
                check_all_low("rst_abort");
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("rst_release_req_ready", 32'(req_ready), 32'd1);
                return;
            end
            if (i == stall_beat) begin
                for (int s = 0; s < 2; s++) begin
                    rdata_ready = 1'b0;
                    check("rd_stall_data", rdata, base + i);
                    check("rd_stall_valid", 32'(rdata_valid), 32'd1);
                    @(negedge clk);
                end
            end
            rdata_ready = 1'b1;
            check("rd_data", rdata, base + i);
            check("rd_valid", 32'(rdata_valid), 32'd1);
            check("rd_last", 32'(rdata_last), (i == 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("rd_end_valid", 32'(rdata_valid), 32'd0);
        check("rd_end_rdata", rdata, 32'd0);
        check("rd_end_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        #2;
        check_all_low("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        do_write(32'h0000_0040, 32'h1000_0000, 1'b0, 1'b0);
        do_read (32'h0000_0040, 32'h1000_0000, 8, 8);
        do_read (32'h0000_005C, 32'h1000_0000, 8, 8);
        do_read (32'h0000_4040, 32'h1000_0000, 8, 8);
        do_read (32'h0000_0040, 32'h1000_0000, 3, 8);
        do_read (32'h0000_0040, 32'h1000_0000, 8, 4);
        do_read (32'h0000_0040, 32'h1000_0000, 8, 8);
        do_write(32'h0000_0080, 32'h2000_0000, 1'b1, 1'b1);
        do_read (32'h0000_0080, 32'h2000_0000, 8, 8);
        do_read (32'h0000_0040, 32'h1000_0000, 8, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
